ii_frame_reader: RTL and testbench
==================================

Name: ii_frame_reader

Overview:
- Frame-level sequencer that feeds the integral / squared-integral generator pair.
- Raster-scans an image buffer through a 1-cycle-latency synchronous read port.
- Emits pixels as a valid/ready stream with row/frame end-of-transfer flags.
- Started per frame by the top-level control; signals done once the last pixel has been accepted downstream.

Parameters:
- W_DATA, 8, pixel width.
- IMG_W, 320, image width in pixels.
- IMG_H, 240, image height in pixels.
- W_ADDR, $clog2(IMG_W*IMG_H), image buffer address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle frame start request.
- busy  output  1  high from accepted start until the done cycle inclusive.
- done  output  1  one-cycle pulse after the last pixel handshake.
- mem_rd_en  output  1  image buffer read strobe.
- mem_addr  output  W_ADDR  image buffer read address.
- mem_rd_data  input  W_DATA  read data, valid exactly 1 cycle after mem_rd_en.
- dout_valid  output  1  pixel stream valid.
- dout_ready  input  1  pixel stream ready.
- dout_data  output  W_DATA  pixel.
- dout_eot  output  2  [0] last pixel of row, [1] last pixel of frame; both set on the final pixel.
- cfg_stride  input  2  only with STRIDE_EN; see Optional Feature.

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, dout_valid=0, dout_data=0, dout_eot=0.
- Reset mid-frame aborts the frame. Any in-flight read data is discarded and the FIFO is emptied. done is not pulsed.
- FSM states:
  - IDLE: start goes to RUN; col/row counters cleared.
  - RUN: issues reads. After issuing the last address, go to DRAIN.
  - DRAIN: no reads. When the FIFO is empty, nothing is in flight, and the last pixel has handshaken, go to DONE.
  - DONE: one cycle, done=1, busy=1; then IDLE.
- start is ignored unless in IDLE. start and rst in the same cycle: rst wins.
- Read issue:
  - A read is issued (mem_rd_en=1) in RUN when fifo_count + inflight < 2.
  - inflight is 1 in the cycle after a read.
  - No FIFO overflow is permitted under any dout_ready pattern.
- Read data is pushed into a 2-entry FIFO together with its eot flags, which are computed at issue time.
- dout_* is driven from the FIFO head. dout_data and dout_eot are held stable while dout_valid && !dout_ready.
- Addressing: mem_addr = row*IMG_W + col. col wraps at IMG_W-1 and row then increments. Use an incrementing address register, not a multiplier.
- Latency: start at cycle 0, mem_rd_en at cycle 1, dout_valid at cycle 2.
- Throughput: 1 pixel/cycle with dout_ready held high.
- Total handshakes per frame = IMG_W*IMG_H.
- The eot[1] pixel is exactly the last handshake. done follows it by 1 cycle.

Optional Feature:
- Macro STRIDE_EN.
- With STRIDE_EN:
  - cfg_stride port is present; stride s = cfg_stride+1 (1..4), sampled on accepted start.
  - Columns visited are 0, s, 2s, … < IMG_W; rows visited likewise.
  - Output frame is ceil(IMG_W/s) x ceil(IMG_H/s).
  - mem_addr = row*IMG_W + col, where row and col are the visited (strided) row and column indices.
  - eot marks the last visited column/row.
- Without STRIDE_EN: no cfg_stride port, s=1, behaviour as above.

Decomposition:
- Package ii_ctrl_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - EOT_ROW=0 and EOT_FRAME=1 bit indices.
  - eot_t typedef (logic [1:0]).
- Sub-module pix_fifo: 2-entry, W_DATA+2 wide, with push/pop/count. Reused elsewhere for skid buffering.

Test Plan:
- IMG_W=4, IMG_H=3, mem holds addr value, dout_ready=1, start → 12 pixels 0..11 on consecutive cycles starting 2 cycles after start.
  - eot=01 on pixels 3 and 7; eot=11 on pixel 11.
  - done one cycle later; busy low after done.
- Same setup, dout_ready toggling 1,0 every cycle → same 12 values in order, data stable while stalled, mem_rd_en never leaves FIFO count > 2, done after last handshake.
- dout_ready=0 for 20 cycles after start → exactly 2 reads issued, then ready=1 → full frame correct.
- start pulsed during busy → ignored; exactly 12 pixels and one done.
- rst asserted at pixel 5 → all outputs at reset values next cycle, no done; new start yields a fresh frame from pixel 0.
- STRIDE_EN, cfg_stride=1 (s=2), IMG_W=5, IMG_H=3 → pixels 0,2,4,10,12,14.
  - eot=01 on pixel 4; eot=11 on pixel 14.

Source files
------------

// File: rtl/ii_ctrl_pkg.sv
// Shared types for the integral-image control path.
// Contents: frame sequencer state enum, end-of-transfer flag indices, eot_t.
// Used by ii_frame_reader and its output FIFO users.
package ii_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit positions inside an eot_t flag pair.
  localparam int EOT_ROW   = 0;
  localparam int EOT_FRAME = 1;

  typedef logic [1:0] eot_t;

endpackage

// File: rtl/pix_fifo.sv
// Two-entry FIFO for pixel words (also used as a skid buffer).
// Ports: clk/rst (sync, active-high), push/din, pop/dout (head), count (0..2).
// The caller guarantees no push when full and no pop when empty.
module pix_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Storage is not reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ii_frame_reader.sv
// Raster-scans an image buffer (1-cycle read latency) into a valid/ready pixel stream.
// Ports: clk/rst, start/busy/done control, mem_rd_en/mem_addr/mem_rd_data read port,
//        dout_valid/dout_ready/dout_data/dout_eot stream, cfg_stride (STRIDE_EN only).
// Optional macro STRIDE_EN: subsample rows and columns by cfg_stride+1.
module ii_frame_reader
  import ii_ctrl_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int W_ADDR = $clog2(IMG_W*IMG_H)
) (
`ifdef STRIDE_EN
  input  logic [1:0]        cfg_stride,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [W_ADDR-1:0] mem_addr,
  input  logic [W_DATA-1:0] mem_rd_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [1:0]        dout_eot
);

  // Counters are wide enough to hold index + stride without wrapping.
  localparam int W_COL = $clog2(IMG_W + 4);
  localparam int W_ROW = $clog2(IMG_H + 4);
  localparam int W_ENT = W_DATA + 2;

  state_t            state_q, state_d;
  logic [W_COL-1:0]  col_q, col_d;
  logic [W_ROW-1:0]  row_q, row_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [W_ADDR-1:0] row_base_q, row_base_d;
  logic [W_ADDR-1:0] row_step_q, row_step_d;
  logic [2:0]        stride_q, stride_d;
  logic              inflight_q;
  eot_t              rd_eot_q, rd_eot_d;

  logic [2:0]        start_stride;
  logic [W_COL-1:0]  col_nxt;
  logic [W_ROW-1:0]  row_nxt;
  eot_t              issue_eot;
  logic              rd_en;
  logic [2:0]        occ;
  logic              hs;

  logic              fifo_push, fifo_pop;
  logic [W_ENT-1:0]  fifo_dout, head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;

`ifdef STRIDE_EN
  assign start_stride = {1'b0, cfg_stride} + 3'd1;
`else
  assign start_stride = 3'd1;
`endif

  // Flags for the pixel about to be read; they travel with its data.
  assign col_nxt               = col_q + W_COL'(stride_q);
  assign row_nxt               = row_q + W_ROW'(stride_q);
  assign issue_eot[EOT_ROW]    = (col_nxt >= W_COL'(IMG_W));
  assign issue_eot[EOT_FRAME]  = issue_eot[EOT_ROW] && (row_nxt >= W_ROW'(IMG_H));

  // Head of stream: FIFO head, or the word arriving from memory this cycle
  // when the FIFO is empty (gives dout_valid one cycle after the read).
  assign fifo_empty = (fifo_count == 2'd0);
  assign head       = fifo_empty ? {rd_eot_q, mem_rd_data} : fifo_dout;
  assign dout_valid = !fifo_empty || inflight_q;
  assign hs         = dout_valid && dout_ready;
  assign fifo_pop   = hs && !fifo_empty;
  assign fifo_push  = inflight_q && !(fifo_empty && dout_ready);

  // Occupancy left after this cycle's handshake. A new read lands next cycle
  // and may find the consumer stalled, so at most one word may remain.
  assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(hs);
  assign rd_en = (state_q == RUN) && (occ <= 3'd1);

  pix_fifo #(.W(W_ENT)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({rd_eot_q, mem_rd_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    row_step_d = row_step_q;
    stride_d   = stride_q;
    rd_eot_d   = rd_en ? issue_eot : rd_eot_q;
    case (state_q)
      IDLE: begin
        col_d      = '0;
        row_d      = '0;
        addr_d     = '0;
        row_base_d = '0;
        if (start) begin
          state_d  = RUN;
          stride_d = start_stride;
          case (start_stride)
            3'd2:    row_step_d = W_ADDR'(2 * IMG_W);
            3'd3:    row_step_d = W_ADDR'(3 * IMG_W);
            3'd4:    row_step_d = W_ADDR'(4 * IMG_W);
            default: row_step_d = W_ADDR'(IMG_W);
          endcase
        end
      end
      RUN: begin
        if (rd_en) begin
          if (issue_eot[EOT_ROW]) begin
            col_d      = '0;
            row_d      = row_nxt;
            row_base_d = row_base_q + row_step_q;
            addr_d     = row_base_q + row_step_q;
          end else begin
            col_d  = col_nxt;
            addr_d = addr_q + W_ADDR'(stride_q);
          end
          if (issue_eot[EOT_FRAME]) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The frame-end pixel is always the final word in the pipe.
        if (hs && head[W_DATA + EOT_FRAME]) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      row_step_q <= '0;
      stride_q   <= 3'd1;
      inflight_q <= 1'b0;
      rd_eot_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      row_step_q <= row_step_d;
      stride_q   <= stride_d;
      inflight_q <= rd_en;
      rd_eot_q   <= rd_eot_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign dout_data = dout_valid ? head[W_DATA-1:0] : '0;
  assign dout_eot  = dout_valid ? head[W_ENT-1:W_DATA] : 2'b00;

endmodule

// File: tb/tb_ii_frame_reader.sv
module tb_ii_frame_reader;

  localparam int W_DATA = 8;
`ifdef STRIDE_EN
  localparam int TW = 5;
  localparam int TH = 3;
  localparam int S  = 2;
`else
  localparam int TW = 4;
  localparam int TH = 3;
  localparam int S  = 1;
`endif
  localparam int TWA = $clog2(TW*TH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              dout_ready = 1'b0;
  logic [W_DATA-1:0] mem_rd_data = '0;
  logic              busy, done, mem_rd_en, dout_valid;
  logic [TWA-1:0]    mem_addr;
  logic [W_DATA-1:0] dout_data;
  logic [1:0]        dout_eot;
`ifdef STRIDE_EN
  logic [1:0]        cfg_stride = 2'(S - 1);
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_pix = 0;
  logic [7:0] exp_dat [$];
  logic [1:0] exp_eot [$];

  ii_frame_reader #(
    .W_DATA(W_DATA), .IMG_W(TW), .IMG_H(TH), .W_ADDR(TWA)
  ) dut (
`ifdef STRIDE_EN
    .cfg_stride  (cfg_stride),
`endif
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_eot    (dout_eot)
  );

  always #5 clk = ~clk;

  // Image buffer: each location holds its own address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= W_DATA'(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      1:       return (k % 2 == 0);
      2:       return (k > 20);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_valid"}, 32'(dout_valid), 0);
    check({tag, "_data"}, 32'(dout_data), 0);
    check({tag, "_eot"}, 32'(dout_eot), 0);
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready low for 20 cycles.
  // abort_at >= 0: assert rst right after that many handshakes.
  task automatic run_frame(input int mode, input int abort_at, input bit extra_start);
    int k, hs_cnt, rd_cnt, rd_stall, max_out, done_cnt, first_hs, last_hs, done_cyc;
    bit prev_stall, ok_stable, aborted, fin;
    logic [7:0] prev_dat;
    logic [1:0] prev_eot;
    hs_cnt = 0; rd_cnt = 0; rd_stall = 0; max_out = 0; done_cnt = 0;
    first_hs = -1; last_hs = -1; done_cyc = -10;
    prev_stall = 0; ok_stable = 1; aborted = 0; fin = 0;
    prev_dat = '0; prev_eot = '0;
    @(negedge clk);
    start = 1'b1;
    dout_ready = rdy(mode, 0);
    @(negedge clk);
    k = 1;
    while (!fin && k < 400) begin
      start = extra_start && (k == 5 || k == n_pix + 2);
      dout_ready = rdy(mode, k);
      #1;
      if (k == 1) begin
        check("lat_rd_en_c1", 32'(mem_rd_en), 1);
        check("lat_valid_c1", 32'(dout_valid), 0);
        check("busy_c1", 32'(busy), 1);
      end
      if (k == 2) check("lat_valid_c2", 32'(dout_valid), 1);
      if (mem_rd_en) begin
        rd_cnt++;
        if (k <= 20) rd_stall++;
      end
      if (prev_stall && !(dout_valid && dout_data == prev_dat && dout_eot == prev_eot))
        ok_stable = 0;
      if (dout_valid && dout_ready) begin
        if (hs_cnt < n_pix) begin
          check("pix_dat", 32'(dout_data), 32'(exp_dat[hs_cnt]));
          check("pix_eot", 32'(dout_eot), 32'(exp_eot[hs_cnt]));
        end else begin
          check("extra_pixel", 32'(hs_cnt), 32'(n_pix - 1));
        end
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        hs_cnt++;
        if (hs_cnt == abort_at) begin
          rst = 1'b1;
          aborted = 1;
          break;
        end
      end
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = k;
        check("busy_at_done", 32'(busy), 1);
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dat = dout_data;
      prev_eot = dout_eot;
      @(negedge clk);
      k++;
      if (done_cnt > 0 && k > done_cyc + 3) fin = 1;
    end
    start = 1'b0;
    if (!aborted) begin
      check("pix_count", 32'(hs_cnt), 32'(n_pix));
      check("done_count", 32'(done_cnt), 1);
      check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
      check("occ_le_2", 32'(max_out <= 2), 1);
      check("busy_after_done", 32'(busy), 0);
      if (mode == 0) begin
        check("first_pix_cycle", 32'(first_hs), 2);
        check("last_pix_cycle", 32'(last_hs), 32'(n_pix + 1));
      end else begin
        check("stable_stall", 32'(ok_stable), 1);
      end
      if (mode == 2) check("reads_while_stalled", 32'(rd_stall), 2);
    end
  endtask

  initial begin
    int seen_done;
    for (int r = 0; r < TH; r += S) begin
      for (int c = 0; c < TW; c += S) begin
        exp_dat.push_back(8'(r * TW + c));
        exp_eot.push_back({(c + S >= TW) && (r + S >= TH), (c + S >= TW)});
      end
    end
    n_pix = exp_dat.size();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);
    run_frame(2, -1, 1'b0);
    run_frame(0, -1, 1'b1);

    run_frame(0, 5, 1'b0);
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 0);

    run_frame(0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
